// File: rtl/rpn_pkg.sv
// Shared types and defaults for the RPN command issuer and its depth tracker.
// Optional feature macro used by the issuer: RPN_DEPTH_CHECK_EN.
package rpn_pkg;

    localparam int RPN_DATA_W    = 8;
    localparam int RPN_OP_W      = 3;
    localparam int RPN_MAX_DEPTH = 8;

    typedef enum logic [2:0] {
        OP_PUSH    = 3'd0,
        OP_POP     = 3'd1,
        OP_ADD     = 3'd2,
        OP_MUL     = 3'd3,
        OP_SUB     = 3'd4,
        OP_DIV     = 3'd5,
        OP_MOD     = 3'd6,
        OP_ILLEGAL = 3'd7
    } rpn_op_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_CALC    = 2'd1,
        ERR_ILLEGAL = 2'd2,
        ERR_DEPTH   = 2'd3
    } rpn_err_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RESULT = 3'd4,
        ST_FLUSH  = 3'd5
    } rpn_state_e;

endpackage

// File: rtl/rpn_depth_tracker.sv
// Shadow copy of the calculator stack depth; flags tokens that would under/overflow it.
module rpn_depth_tracker
    import rpn_pkg::*;
#(
    parameter int OP_W      = RPN_OP_W,
    parameter int MAX_DEPTH = RPN_MAX_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] op,
    input  logic            commit,
    input  logic            clr,
    output logic            ok
);

    localparam int CNT_W = $clog2(MAX_DEPTH + 1);

    logic [CNT_W-1:0] depth_reg;
    logic [CNT_W-1:0] depth_next;

    always_comb begin
        ok = 1'b1;
        case (op)
            OP_W'(OP_PUSH):    ok = (depth_reg < CNT_W'(MAX_DEPTH));
            OP_W'(OP_POP):     ok = (depth_reg >= CNT_W'(1));
            OP_W'(OP_ILLEGAL): ok = 1'b1;
            default:           ok = (depth_reg >= CNT_W'(2));
        endcase
    end

    // Binary ops consume two entries and push one back: net -1, same as pop.
    always_comb begin
        depth_next = depth_reg;
        if (clr) begin
            depth_next = '0;
        end else if (commit && ok) begin
            case (op)
                OP_W'(OP_PUSH):    depth_next = depth_reg + CNT_W'(1);
                OP_W'(OP_ILLEGAL): depth_next = depth_reg;
                default:           depth_next = depth_reg - CNT_W'(1);
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            depth_reg <= '0;
        end else begin
            depth_reg <= depth_next;
        end
    end

endmodule

// File: rtl/rpn_cmd_issuer.sv
// Sequences an RPN token stream into one calculator command per token and returns one result per expression.
// Optional shadow depth checking is enabled by defining RPN_DEPTH_CHECK_EN.
module rpn_cmd_issuer
    import rpn_pkg::*;
#(
    parameter int DATA_W    = RPN_DATA_W,
    parameter int OP_W      = RPN_OP_W,
    parameter int MAX_DEPTH = RPN_MAX_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tok_valid,
    output logic              tok_ready,
    input  logic [OP_W-1:0]   tok_op,
    input  logic [DATA_W-1:0] tok_data,
    input  logic              tok_last,
    output logic [DATA_W-1:0] calc_in,
    output logic [OP_W-1:0]   calc_op,
    output logic              calc_apply,
    output logic              calc_rst,
    input  logic [DATA_W-1:0] calc_tail,
    input  logic              calc_empty,
    input  logic              calc_valid,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [1:0]        res_err,
    output logic [7:0]        res_cnt
);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_ISSUE  = ST_ISSUE;
    localparam logic [2:0] S_WAIT   = ST_WAIT;
    localparam logic [2:0] S_DRAIN  = ST_DRAIN;
    localparam logic [2:0] S_RESULT = ST_RESULT;
    localparam logic [2:0] S_FLUSH  = ST_FLUSH;

    logic [2:0]        state_reg, state_next;
    logic              last_reg;
    logic [DATA_W-1:0] calc_in_reg;
    logic [OP_W-1:0]   calc_op_reg;
    logic [DATA_W-1:0] res_data_reg, res_data_next;
    logic [1:0]        res_err_reg, res_err_next;
    logic [7:0]        res_cnt_reg, res_cnt_next;
    logic              tok_ready_reg;
    logic              calc_apply_reg;
    logic              calc_rst_reg;
    logic              res_valid_reg;
    logic              accept;
    logic              issue;
    logic              depth_ok;

    assign accept = tok_valid & tok_ready_reg;

`ifdef RPN_DEPTH_CHECK_EN
    rpn_depth_tracker #(
        .OP_W      (OP_W),
        .MAX_DEPTH (MAX_DEPTH)
    ) u_depth (
        .clk    (clk),
        .rst    (rst),
        .op     (tok_op),
        .commit (issue),
        .clr    (state_reg == S_FLUSH),
        .ok     (depth_ok)
    );
`else
    // A zero-capacity configuration can never accept a command.
    assign depth_ok = (MAX_DEPTH > 0);
`endif

    always_comb begin
        state_next    = state_reg;
        res_data_next = res_data_reg;
        res_err_next  = res_err_reg;
        res_cnt_next  = res_cnt_reg;
        issue         = 1'b0;

        if (accept && (res_cnt_reg != 8'hFF)) begin
            res_cnt_next = res_cnt_reg + 8'd1;
        end

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (tok_op == OP_W'(OP_ILLEGAL)) begin
                        res_err_next = ERR_ILLEGAL;
                        state_next   = tok_last ? S_RESULT : S_DRAIN;
                    end else if (!depth_ok) begin
                        res_err_next = ERR_DEPTH;
                        state_next   = tok_last ? S_RESULT : S_DRAIN;
                    end else begin
                        issue      = 1'b1;
                        state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_next = S_WAIT;
            end
            // The calculator registered the command on the edge that ended ISSUE.
            S_WAIT: begin
                if (!calc_valid) begin
                    res_err_next = ERR_CALC;
                    state_next   = last_reg ? S_RESULT : S_DRAIN;
                end else if (last_reg) begin
                    if (calc_empty) begin
                        res_err_next = ERR_CALC;
                    end else begin
                        res_data_next = calc_tail;
                        res_err_next  = ERR_OK;
                    end
                    state_next = S_RESULT;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (accept && tok_last) begin
                    state_next = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    res_data_next = '0;
                    res_err_next  = ERR_OK;
                    res_cnt_next  = '0;
                    state_next    = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Handshake/strobe outputs are registered from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            last_reg       <= 1'b0;
            calc_in_reg    <= '0;
            calc_op_reg    <= '0;
            res_data_reg   <= '0;
            res_err_reg    <= ERR_OK;
            res_cnt_reg    <= '0;
            tok_ready_reg  <= 1'b0;
            calc_apply_reg <= 1'b0;
            calc_rst_reg   <= 1'b1;
            res_valid_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            res_data_reg   <= res_data_next;
            res_err_reg    <= res_err_next;
            res_cnt_reg    <= res_cnt_next;
            tok_ready_reg  <= (state_next == S_IDLE) || (state_next == S_DRAIN);
            calc_apply_reg <= (state_next == S_ISSUE);
            calc_rst_reg   <= (state_next == S_FLUSH);
            res_valid_reg  <= (state_next == S_RESULT);
            if (accept) begin
                last_reg <= tok_last;
            end
            if (issue) begin
                calc_in_reg <= tok_data;
                calc_op_reg <= tok_op;
            end
        end
    end

    assign tok_ready  = tok_ready_reg;
    assign calc_in    = calc_in_reg;
    assign calc_op    = calc_op_reg;
    assign calc_apply = calc_apply_reg;
    assign calc_rst   = calc_rst_reg;
    assign res_valid  = res_valid_reg;
    assign res_data   = res_data_reg;
    assign res_err    = res_err_reg;
    assign res_cnt    = res_cnt_reg;

endmodule

// File: tb/tb_rpn_cmd_issuer.sv
// Directed bench: rpn_cmd_issuer driving a behavioural 8-deep stack calculator model.
module tb_rpn_cmd_issuer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tok_valid;
    logic       tok_ready;
    logic [2:0] tok_op;
    logic [7:0] tok_data;
    logic       tok_last;
    logic [7:0] calc_in;
    logic [2:0] calc_op;
    logic       calc_apply;
    logic       calc_rst;
    logic [7:0] calc_tail;
    logic       calc_empty;
    logic       calc_valid;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [1:0] res_err;
    logic [7:0] res_cnt;

    int checks   = 0;
    int failures = 0;
    int apply_cnt = 0;
    int a0;
    logic drop_div = 1'b0;

    always #5 clk = ~clk;

    rpn_cmd_issuer dut (
        .clk        (clk),
        .rst        (rst),
        .tok_valid  (tok_valid),
        .tok_ready  (tok_ready),
        .tok_op     (tok_op),
        .tok_data   (tok_data),
        .tok_last   (tok_last),
        .calc_in    (calc_in),
        .calc_op    (calc_op),
        .calc_apply (calc_apply),
        .calc_rst   (calc_rst),
        .calc_tail  (calc_tail),
        .calc_empty (calc_empty),
        .calc_valid (calc_valid),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_err    (res_err),
        .res_cnt    (res_cnt)
    );

    // Calculator model: sticky error flag, synchronous active-high reset.
    logic [7:0] stk [0:7];
    int         depth_m = 0;
    logic       valid_m = 1'b1;

    function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd2:    return a + b;
            3'd3:    return a * b;
            3'd4:    return a - b;
            3'd5:    return a / b;
            default: return a % b;
        endcase
    endfunction

    always @(posedge clk) begin
        if (calc_rst) begin
            depth_m <= 0;
            valid_m <= 1'b1;
        end else if (calc_apply && valid_m) begin
            case (calc_op)
                3'd0: begin
                    if (depth_m == 8) valid_m <= 1'b0;
                    else begin
                        stk[depth_m] <= calc_in;
                        depth_m <= depth_m + 1;
                    end
                end
                3'd1: begin
                    if (depth_m < 1) valid_m <= 1'b0;
                    else depth_m <= depth_m - 1;
                end
                default: begin
                    if (depth_m < 2 || calc_op == 3'd7 || (drop_div && calc_op == 3'd5) ||
                        ((calc_op == 3'd5 || calc_op == 3'd6) && stk[depth_m-1] == 8'd0))
                        valid_m <= 1'b0;
                    else begin
                        stk[depth_m-2] <= alu(calc_op, stk[depth_m-2], stk[depth_m-1]);
                        depth_m <= depth_m - 1;
                    end
                end
            endcase
        end
    end

    assign calc_tail  = (depth_m > 0) ? stk[depth_m-1] : 8'd0;
    assign calc_empty = (depth_m == 0);
    assign calc_valid = valid_m;

    always @(posedge clk) begin
        if (calc_apply === 1'b1) apply_cnt <= apply_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_tok(input logic [2:0] op, input logic [7:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        tok_valid = 1'b1;
        tok_op    = op;
        tok_data  = d;
        tok_last  = l;
        while (tok_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("tok_accept_timeout", (n < 50), 1);
        @(posedge clk);
        #1;
        tok_valid = 1'b0;
    endtask

    task automatic wait_res();
        int n = 0;
        while (res_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("res_valid_timeout", (n < 60), 1);
    endtask

    task automatic finish_expr(input string name, input logic [7:0] d, input logic [1:0] e, input logic [7:0] c);
        wait_res();
        @(negedge clk);
        chk({name, "_data"}, res_data, d);
        chk({name, "_err"}, res_err, e);
        chk({name, "_cnt"}, res_cnt, c);
        chk({name, "_tok_ready_in_result"}, tok_ready, 0);
        $display("expr %s: data=%0d err=%0d cnt=%0d", name, res_data, res_err, res_cnt);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk({name, "_flush_calc_rst"}, calc_rst, 1);
        chk({name, "_flush_res_valid"}, res_valid, 0);
        chk({name, "_flush_cnt"}, res_cnt, 0);
        @(negedge clk);
        chk({name, "_idle_calc_rst"}, calc_rst, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst       = 1'b0;
        tok_valid = 1'b0;
        tok_op    = 3'd0;
        tok_data  = 8'd0;
        tok_last  = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tok_ready", tok_ready, 0);
        chk("rst_calc_rst", calc_rst, 1);
        chk("rst_calc_apply", calc_apply, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_err", res_err, 0);
        chk("rst_res_cnt", res_cnt, 0);
        rst = 1'b1;

        // 1: 6 3 + -> 9
        a0 = apply_cnt;
        send_tok(3'd0, 8'd6, 1'b0);
        chk("t1_issue_apply", calc_apply, 1);
        chk("t1_issue_op", calc_op, 0);
        chk("t1_issue_in", calc_in, 6);
        send_tok(3'd0, 8'd3, 1'b0);
        send_tok(3'd2, 8'd0, 1'b1);
        finish_expr("t1", 8'd9, 2'd0, 8'd3);
        chk("t1_applies", apply_cnt - a0, 3);

        // 2: 4 5 * with res_ready withheld
        send_tok(3'd0, 8'd4, 1'b0);
        send_tok(3'd0, 8'd5, 1'b0);
        send_tok(3'd3, 8'd0, 1'b1);
        wait_res();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_hold_valid", res_valid, 1);
            chk("t2_hold_data", res_data, 20);
            chk("t2_hold_tok_ready", tok_ready, 0);
        end
        finish_expr("t2", 8'd20, 2'd0, 8'd3);

        // 3: illegal opcode mid-expression, rest drained
        a0 = apply_cnt;
        send_tok(3'd0, 8'd1, 1'b0);
        send_tok(3'd7, 8'd0, 1'b0);
        send_tok(3'd0, 8'd2, 1'b0);
        send_tok(3'd1, 8'd0, 1'b1);
        finish_expr("t3", 8'd0, 2'd2, 8'd4);
        chk("t3_applies", apply_cnt - a0, 1);

        // 4: calculator drops valid on div
        drop_div = 1'b1;
        send_tok(3'd0, 8'd0, 1'b0);
        send_tok(3'd0, 8'd3, 1'b0);
        send_tok(3'd5, 8'd0, 1'b1);
        finish_expr("t4", 8'd0, 2'd1, 8'd3);
        drop_div = 1'b0;

        // 5: reset pulse while in WAIT
        send_tok(3'd0, 8'd9, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("t5_rst_calc_rst", calc_rst, 1);
        chk("t5_rst_tok_ready", tok_ready, 0);
        chk("t5_rst_calc_apply", calc_apply, 0);
        chk("t5_rst_calc_in", calc_in, 0);
        chk("t5_rst_res_valid", res_valid, 0);
        chk("t5_rst_res_cnt", res_cnt, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send_tok(3'd0, 8'd7, 1'b1);
        finish_expr("t5", 8'd7, 2'd0, 8'd1);

        // 6: add on a single-entry stack
        a0 = apply_cnt;
        send_tok(3'd0, 8'd5, 1'b0);
        send_tok(3'd2, 8'd0, 1'b1);
`ifdef RPN_DEPTH_CHECK_EN
        finish_expr("t6", 8'd0, 2'd3, 8'd2);
        chk("t6_applies", apply_cnt - a0, 1);
`else
        finish_expr("t6", 8'd0, 2'd1, 8'd2);
        chk("t6_applies", apply_cnt - a0, 2);
`endif

        // 7: 9 4 - 3 % -> 2
        send_tok(3'd0, 8'd9, 1'b0);
        send_tok(3'd0, 8'd4, 1'b0);
        send_tok(3'd4, 8'd0, 1'b0);
        send_tok(3'd0, 8'd3, 1'b0);
        send_tok(3'd6, 8'd0, 1'b1);
        finish_expr("t7", 8'd2, 2'd0, 8'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
